// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined bitwise logic unit: opcode encoding and reduction flags.
package logic_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } logic_op_e;

    typedef struct packed {
        logic and_r;
        logic or_r;
        logic xor_r;
    } reduce_flags_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise gate: selects one of eight WIDTH-wide logic functions of (a, b).
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic_op_e        op,
    output logic [WIDTH-1:0] y_c
);

    always_comb begin
        y_c = a;
        unique case (op)
            OP_AND:  y_c = a & b;
            OP_OR:   y_c = a | b;
            OP_NOT:  y_c = ~a;
            OP_NAND: y_c = ~(a & b);
            OP_NOR:  y_c = ~(a | b);
            OP_XOR:  y_c = a ^ b;
            OP_XNOR: y_c = ~(a ^ b);
            OP_BUF:  y_c = a;
            default: y_c = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with saturating completion counter.
// Optional reduction flags on the result are built when LOGIC_UNIT_REDUCE_EN is defined.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [OP_W-1:0]  out_op,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_REDUCE_EN
    ,
    output logic             out_and_r,
    output logic             out_or_r,
    output logic             out_xor_r
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s2_ready;
    logic             in_hs;
    logic             s1_xfer;
    logic             out_hs;

    logic             s1_valid_d, s1_valid_q;
    logic [WIDTH-1:0] s1_a_d,     s1_a_q;
    logic [WIDTH-1:0] s1_b_d,     s1_b_q;
    logic_op_e        s1_op_d,    s1_op_q;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_y_d,     out_y_q;
    logic_op_e        out_op_d,    out_op_q;
    logic             out_zero_d,  out_zero_q;
    logic [CNT_W-1:0] op_count_d,  op_count_q;

    logic [WIDTH-1:0] core_y;

    // Ready chain: a stage can take data when it is empty or emptying this cycle.
    always_comb begin
        s2_ready = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_ready;
        in_hs    = in_valid && in_ready;
        s1_xfer  = s1_valid_q && s2_ready;
        out_hs   = out_valid_q && out_ready;
    end

    // Stage 1: operand capture; a drain and refill in the same cycle keeps it full.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (in_hs) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = logic_op_e'(in_op);
        end else if (s1_xfer) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_AND;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .op  (s1_op_q),
        .y_c (core_y)
    );

    // Stage 2: result register, frozen while the consumer stalls.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_op_d    = out_op_q;
        out_zero_d  = out_zero_q;
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_y_d    = core_y;
                out_op_d   = s1_op_q;
                out_zero_d = (core_y == '0);
            end
        end
    end

    // Completed-handshake counter, sticks at all-ones.
    always_comb begin
        op_count_d = op_count_q;
        if (out_hs && (op_count_q != CNT_MAX)) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_op_q    <= OP_AND;
            out_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_op_q    <= out_op_d;
            out_zero_q  <= out_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_op    = out_op_q;
    assign out_zero  = out_zero_q;
    assign op_count  = op_count_q;

`ifdef LOGIC_UNIT_REDUCE_EN
    reduce_flags_t red_d, red_q;

    // Reduction flags follow the same load/hold rule as out_y.
    always_comb begin
        red_d = red_q;
        if (s1_xfer) begin
            red_d.and_r = &core_y;
            red_d.or_r  = |core_y;
            red_d.xor_r = ^core_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q <= '0;
        end else begin
            red_q <= red_d;
        end
    end

    assign out_and_r = red_q.and_r;
    assign out_or_r  = red_q.or_r;
    assign out_xor_r = red_q.xor_r;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed cases plus randomized traffic against a queue model.
// Reduction flag checks are included when LOGIC_UNIT_REDUCE_EN is defined.
module tb_logic_unit_pipe;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_ready;

    logic             in_ready,  in_ready2;
    logic             out_valid, out_valid2;
    logic [WIDTH-1:0] out_y,     out_y2;
    logic [2:0]       out_op,    out_op2;
    logic             out_zero,  out_zero2;
    logic [15:0]      op_count;
    logic [1:0]       op_count2;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic             and_r, or_r, xor_r;
    logic             and_r2, or_r2, xor_r2;
`endif

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_op(out_op), .out_zero(out_zero),
        .op_count(op_count)
`ifdef LOGIC_UNIT_REDUCE_EN
        , .out_and_r(and_r), .out_or_r(or_r), .out_xor_r(xor_r)
`endif
    );

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid2),
        .out_ready(out_ready), .out_y(out_y2), .out_op(out_op2), .out_zero(out_zero2),
        .op_count(op_count2)
`ifdef LOGIC_UNIT_REDUCE_EN
        , .out_and_r(and_r2), .out_or_r(or_r2), .out_xor_r(xor_r2)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_gate(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    typedef struct {
        logic [WIDTH-1:0] y;
        logic [2:0]       op;
    } exp_t;

    exp_t             sb[$];
    int               exp_cnt = 0;
    int               n_in = 0;
    int               n_out = 0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] held_y;
    logic [2:0]       held_op;
    logic             held_zero;

    // Monitor: inputs are stable at the falling edge, so handshakes seen here happen at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
            check_eq("in_ready_sat", 64'(in_ready2), 64'((sb.size() < 2) || out_ready));
            if (sb.size() == 2) check_eq("full_out_valid", 64'(out_valid), 64'(1));
            if (sb.size() == 0) check_eq("empty_out_valid", 64'(out_valid), 64'(0));
            if (stall_prev) begin
                check_eq("hold_y", 64'(out_y), 64'(held_y));
                check_eq("hold_op", 64'(out_op), 64'(held_op));
                check_eq("hold_zero", 64'(out_zero), 64'(held_zero));
            end
            check_eq("op_count", 64'(op_count), 64'(exp_cnt));
            check_eq("op_count_sat", 64'(op_count2), 64'((exp_cnt > 3) ? 3 : exp_cnt));
            if (out_valid && out_ready) begin
                exp_t e;
                check_eq("sb_nonempty", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("out_y", 64'(out_y), 64'(e.y));
                    check_eq("out_op", 64'(out_op), 64'(e.op));
                    check_eq("out_zero", 64'(out_zero), 64'(e.y == 0));
                    check_eq("out_valid_sat", 64'(out_valid2), 64'(1));
                    check_eq("out_y_sat", 64'(out_y2), 64'(e.y));
                    check_eq("out_op_sat", 64'(out_op2), 64'(e.op));
                    check_eq("out_zero_sat", 64'(out_zero2), 64'(e.y == 0));
`ifdef LOGIC_UNIT_REDUCE_EN
                    check_eq("and_r", 64'(and_r), 64'(e.y == 8'hFF));
                    check_eq("or_r", 64'(or_r), 64'(e.y != 0));
                    check_eq("xor_r", 64'(xor_r), 64'($countones(e.y) % 2));
                    check_eq("and_r_sat", 64'(and_r2), 64'(e.y == 8'hFF));
                    check_eq("or_r_sat", 64'(or_r2), 64'(e.y != 0));
                    check_eq("xor_r_sat", 64'(xor_r2), 64'($countones(e.y) % 2));
`endif
                end
                if (exp_cnt < 65535) exp_cnt++;
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.y  = ref_gate(in_a, in_b, in_op);
                n.op = in_op;
                sb.push_back(n);
                n_in++;
            end
            stall_prev = out_valid && !out_ready;
            held_y     = out_y;
            held_op    = out_op;
            held_zero  = out_zero;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        exp_cnt    = 0;
        n_out      = 0;
        stall_prev = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_y", 64'(out_y), 64'(0));
        check_eq("rst_out_op", 64'(out_op), 64'(0));
        check_eq("rst_out_zero", 64'(out_zero), 64'(0));
        check_eq("rst_op_count", 64'(op_count), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef LOGIC_UNIT_REDUCE_EN
        check_eq("rst_flags", 64'({and_r, or_r, xor_r}), 64'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] dir_exp[8] = '{8'h42, 8'hDB, 8'h3C, 8'hBD, 8'h24, 8'h99, 8'h66, 8'hC3};
    logic [WIDTH-1:0] bp_a[3];
    logic [WIDTH-1:0] bp_b[3];
    logic [2:0]       bp_op[3];

    initial begin
        int cyc;
        int n0;
        int out0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        #2;
        do_reset();

        // All eight opcodes streamed back to back on one operand pair.
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h5A; in_op = 3'(j);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j < 2) begin
                check_eq("dir_latency", 64'(out_valid), 64'(0));
            end else begin
                check_eq("dir_valid", 64'(out_valid), 64'(1));
                check_eq("dir_y", 64'(out_y), 64'(dir_exp[j-2]));
                check_eq("dir_op", 64'(out_op), 64'(j - 2));
            end
            @(posedge clk);
            #1;
        end

        // Zero result then all-ones result.
        for (int j = 0; j < 4; j++) begin
            if (j < 2) begin
                in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h0F; in_op = (j == 0) ? 3'd0 : 3'd5;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j >= 2) begin
                check_eq("zf_y", 64'(out_y), (j == 2) ? 64'h00 : 64'hFF);
                check_eq("zf_zero", 64'(out_zero), (j == 2) ? 64'd1 : 64'd0);
`ifdef LOGIC_UNIT_REDUCE_EN
                check_eq("zf_flags", 64'({and_r, or_r, xor_r}), (j == 2) ? 64'b000 : 64'b110);
`endif
            end
            @(posedge clk);
            #1;
        end

        // Back-pressure: two beats fill the pipe, the third is refused until the consumer drains.
        for (int k = 0; k < 3; k++) begin
            bp_a[k]  = 8'($urandom);
            bp_b[k]  = 8'($urandom);
            bp_op[k] = 3'($urandom);
        end
        out_ready = 1'b0;
        out0      = n_out;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_a = bp_a[k]; in_b = bp_b[k]; in_op = bp_op[k];
            @(negedge clk);
            check_eq("bp_accept", 64'(in_ready), 64'(1));
            @(posedge clk);
            #1;
        end
        in_a = bp_a[2]; in_b = bp_b[2]; in_op = bp_op[2];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_block", 64'(in_ready), 64'(0));
            check_eq("bp_stable_y", 64'(out_y), 64'(ref_gate(bp_a[0], bp_b[0], bp_op[0])));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        cyc = 0;
        while (in_valid && cyc < 10) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            cyc++;
        end
        check_eq("bp_third_taken", 64'(in_valid), 64'(0));
        cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("bp_drained", 64'(sb.size()), 64'(0));
        check_eq("bp_out_beats", 64'(n_out - out0), 64'(3));

        // Saturation of the 2-bit counter over five handshakes.
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j < 5) begin
                in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j >= 3) begin
                check_eq("cnt_sat_seq", 64'(op_count2), 64'((j - 2 > 3) ? 3 : j - 2));
                check_eq("cnt_seq", 64'(op_count), 64'(j - 2));
            end
            @(posedge clk);
            #1;
        end

        // Reset with both stages full, then no spontaneous output afterwards.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_full", 64'(out_valid), 64'(1));
        #2;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("post_rst_idle", 64'(out_valid), 64'(0));
            @(posedge clk);
            #1;
        end

        // Random valid/ready traffic.
        do_reset();
        n0  = n_in;
        cyc = 0;
        while ((n_in - n0) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_op     = 3'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("rand_beats", 64'(n_in - n0), 64'(10000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(negedge clk);
        check_eq("rand_drained", 64'(sb.size()), 64'(0));
        check_eq("rand_count", 64'(op_count), 64'(n_out));
        check_eq("rand_in_out", 64'(n_out), 64'(10000));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
